// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - accelerator-wide sizing constants and feature word type
package acc_pkg;
  localparam int HIT  = 56;
  localparam int DW   = 32;
  localparam int IW   = 16;
  localparam int FW   = 16;
  localparam int IDXW = $clog2(HIT);

  typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/fmap_ser2par_if.sv
// rtl/fmap_ser2par_if.sv - valid/ready/last stream of width W
interface fmap_ser2par_if #(parameter int W = 32);
  logic [W-1:0] data;
  logic         valid;
  logic         last;
  logic         ready;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/fmap_ser2par_col_bank.sv
// rtl/fmap_ser2par_col_bank.sv - one HIT-word column buffer with full/last flags
module col_bank
  import acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDXW-1:0]   idx,
  input  word_t             wdata,
  input  logic              zfill,
  input  logic              set,
  input  logic              set_last,
  input  logic              clr,
  output logic [HIT*DW-1:0] col,
  output logic              full,
  output logic              last
);
  word_t [HIT-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      full <= 1'b0;
      last <= 1'b0;
    end else begin
      // A short column zeroes every word above the closing index in the same edge
      if (we) begin
        for (int i = 0; i < HIT; i++) begin
          if (IDXW'(i) == idx)
            mem[i] <= wdata;
          else if (zfill && (IDXW'(i) > idx))
            mem[i] <= '0;
        end
      end
      if (clr) begin
        full <= 1'b0;
      end else if (set) begin
        full <= 1'b1;
        last <= set_last;
      end
    end
  end

  assign col = mem;
endmodule

// File: rtl/fmap_ser2par.sv
// rtl/fmap_ser2par.sv - serial feature words to HIT-word columns, ping-pong banked
module fmap_ser2par
  import acc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  fmap_ser2par_if.slave        s,
  fmap_ser2par_if.master       m,
  output logic                 err_short
);
  logic              wr_sel, rd_sel;
  logic [IDXW-1:0]   wr_idx;
  logic [1:0]        full, last;
  logic [HIT*DW-1:0] col [2];

  logic wr_fire, rd_fire, at_end, close;

  assign s.ready = !full[wr_sel];
  assign m.valid = full[rd_sel];
  assign m.last  = last[rd_sel];
  assign m.data  = col[rd_sel];

  assign wr_fire = s.valid && s.ready;
  assign rd_fire = m.valid && m.ready;
  assign at_end  = (wr_idx == IDXW'(HIT-1));
  assign close   = wr_fire && (at_end || s.last);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    col_bank u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wr_fire && (wr_sel == 1'(b))),
      .idx      (wr_idx),
      .wdata    (s.data),
      .zfill    (s.last),
      .set      (close && (wr_sel == 1'(b))),
      .set_last (s.last),
      .clr      (rd_fire && (rd_sel == 1'(b))),
      .col      (col[b]),
      .full     (full[b]),
      .last     (last[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_idx    <= '0;
      err_short <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (close) begin
          wr_sel <= ~wr_sel;
          wr_idx <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
        if (s.last && !at_end)
          err_short <= 1'b1;
      end
      if (rd_fire)
        rd_sel <= ~rd_sel;
    end
  end
endmodule

// File: tb/tb_fmap_ser2par.sv
// tb/tb_fmap_ser2par.sv - directed self-checking bench for fmap_ser2par
module tb_fmap_ser2par;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_short;
  int   checks = 0;
  int   failures = 0;

  fmap_ser2par_if #(.W(DW))     s_if ();
  fmap_ser2par_if #(.W(HIT*DW)) m_if ();

  fmap_ser2par dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s_if.slave),
    .m         (m_if.master),
    .err_short (err_short)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_col(input string tag, input logic [HIT*DW-1:0] exp);
    int bad;
    bad = -1;
    for (int i = HIT-1; i >= 0; i--)
      if (m_if.data[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
    checks++;
    assert (m_if.data === exp) else begin
      failures++;
      $error("FAIL %s word %0d observed=%h expected=%h", tag, bad,
             m_if.data[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_if.data  = d;
    s_if.last  = l;
    s_if.valid = 1'b1;
    while (!s_if.ready && n < 3000) begin
      step();
      n++;
    end
    if (n == 3000) chk("send_timeout", 32'(s_if.ready), 32'd1);
    step();
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic consume();
    m_if.ready = 1'b1;
    step();
    m_if.ready = 1'b0;
  endtask

  logic [HIT*DW-1:0] exp_a, exp_b, prev_col;
  logic [HIT*DW-1:0] expq [$];
  logic              lastq [$];
  int                hs_cnt, hs_prev, got, cyc, len;
  logic              spacing_ok, ready_drop, hold, prev_last;

  initial begin
    s_if.data  = '0;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b0;
    #2;
    chk("rst_m_valid", 32'(m_if.valid), 32'd0);
    chk("rst_m_last", 32'(m_if.last), 32'd0);
    chk("rst_s_ready", 32'(s_if.ready), 32'd1);
    chk("rst_err", 32'(err_short), 32'd0);
    chk_col("rst_fmap", '0);
    step();
    rst_n = 1'b1;
    step();

    // full column, array not ready
    for (int i = 0; i < HIT; i++) begin
      exp_a[i*DW +: DW] = 32'h100 + i;
      exp_b[i*DW +: DW] = 32'h100 + HIT + i;
    end
    for (int i = 0; i < HIT; i++) begin
      send(32'h100 + i, 1'b0);
      if (i == HIT-2) chk("valid_before_close", 32'(m_if.valid), 32'd0);
    end
    chk("full_m_valid", 32'(m_if.valid), 32'd1);
    chk_col("full_col", exp_a);
    chk("full_m_last", 32'(m_if.last), 32'd0);
    chk("full_s_ready", 32'(s_if.ready), 32'd1);

    // second column fills the other bank, input then stalls
    for (int i = HIT; i < 2*HIT; i++) send(32'h100 + i, 1'b0);
    chk("bp_s_ready", 32'(s_if.ready), 32'd0);
    chk_col("bp_shows_bank0", exp_a);
    consume();
    chk_col("bp_shows_bank1", exp_b);
    chk("bp_m_valid", 32'(m_if.valid), 32'd1);
    chk("bp_s_ready_back", 32'(s_if.ready), 32'd1);
    consume();
    chk("bp_drained", 32'(m_if.valid), 32'd0);

    // sustained streaming
    m_if.ready = 1'b1;
    hs_cnt = 0; hs_prev = 0; spacing_ok = 1'b1; ready_drop = 1'b0;
    fork
      begin
        s_if.valid = 1'b1;
        for (int c = 0; c < 10; c++)
          for (int i = 0; i < HIT; i++) begin
            s_if.data = 32'(c*1000 + i);
            if (!s_if.ready) ready_drop = 1'b1;
            step();
          end
        s_if.valid = 1'b0;
      end
      begin
        for (int t = 0; t < 700; t++) begin
          @(negedge clk);
          if (m_if.valid && m_if.ready) begin
            if (hs_cnt > 0 && (t - hs_prev) != HIT) spacing_ok = 1'b0;
            hs_prev = t;
            hs_cnt++;
          end
        end
      end
    join
    m_if.ready = 1'b0;
    chk("sus_handshakes", 32'(hs_cnt), 32'd10);
    chk("sus_spacing", 32'(spacing_ok), 32'd1);
    chk("sus_ready_drop", 32'(ready_drop), 32'd0);

    // short column: last on word 19
    exp_a = '0;
    for (int i = 0; i < 20; i++) exp_a[i*DW +: DW] = 32'(i + 1);
    for (int i = 0; i < 20; i++) send(32'(i + 1), i == 19);
    chk_col("short_col", exp_a);
    chk("short_m_last", 32'(m_if.last), 32'd1);
    chk("short_err", 32'(err_short), 32'd1);
    for (int i = 0; i < HIT; i++) exp_b[i*DW +: DW] = 32'h200 + i;
    for (int i = 0; i < HIT; i++) send(32'h200 + i, 1'b0);
    consume();
    chk_col("after_short_col", exp_b);
    chk("after_short_m_last", 32'(m_if.last), 32'd0);
    chk("after_short_err", 32'(err_short), 32'd1);
    consume();

    // async reset mid-column with one column pending
    for (int i = 0; i < HIT; i++) send(32'h400 + i, 1'b0);
    for (int i = 0; i < 31; i++) send(32'h500 + i, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_if.valid), 32'd0);
    chk("arst_s_ready", 32'(s_if.ready), 32'd1);
    chk("arst_err", 32'(err_short), 32'd0);
    chk_col("arst_fmap", '0);
    step();
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < HIT; i++) exp_a[i*DW +: DW] = 32'h300 + i;
    for (int i = 0; i < HIT; i++) send(32'h300 + i, 1'b0);
    chk_col("post_rst_col", exp_a);
    chk("post_rst_m_last", 32'(m_if.last), 32'd0);
    consume();

    // random gaps on both sides with scoreboard
    got = 0; cyc = 0; hold = 1'b0; prev_col = '0; prev_last = 1'b0;
    fork
      begin
        for (int c = 0; c < 20; c++) begin
          logic [HIT*DW-1:0] col_v;
          logic [31:0]       w;
          len = ($urandom_range(0, 1) == 1) ? HIT : int'($urandom_range(1, HIT-1));
          col_v = '0;
          for (int i = 0; i < len; i++) col_v[i*DW +: DW] = 32'(c*100 + i + 7);
          expq.push_back(col_v);
          lastq.push_back(len < HIT);
          for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) step();
            w = col_v[i*DW +: DW];
            send(w, (i == len-1) && (len < HIT));
          end
        end
      end
      begin
        while (got < 20 && cyc < 20000) begin
          @(posedge clk);
          #1;
          m_if.ready = ($urandom_range(0, 1) == 1);
          @(negedge clk);
          cyc++;
          if (hold) begin
            chk_col("hold_fmap", prev_col);
            chk("hold_m_valid", 32'(m_if.valid), 32'd1);
            chk("hold_m_last", 32'(m_if.last), 32'(prev_last));
          end
          if (m_if.valid && m_if.ready) begin
            chk_col("rand_col", expq.pop_front());
            chk("rand_m_last", 32'(m_if.last), 32'(lastq.pop_front()));
            got++;
          end
          hold = m_if.valid && !m_if.ready;
          prev_col = m_if.data;
          prev_last = m_if.last;
        end
      end
    join
    m_if.ready = 1'b0;
    chk("rand_columns", 32'(got), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
